keypad_emulator: RTL

KEYPAD_EMULATOR -- requirements
Module: keypad_emulator

---
 rtl/keypad_pkg.sv | 39 +++
 rtl/keypad_code_to_pos.sv | 23 ++
 rtl/keypad_emulator.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared key codes, FSM state encodings and the physical 4x4 keypad layout.
package keypad_pkg;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_HASH = 4'd14;
    localparam logic [3:0] KEY_STAR = 4'd15;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_BOUNCE_IN  = 3'd1;
    localparam logic [2:0] ST_HOLD       = 3'd2;
    localparam logic [2:0] ST_BOUNCE_OUT = 3'd3;
    localparam logic [2:0] ST_GAP        = 3'd4;

    // Indexed [row][col], columns left to right.
    localparam logic [3:0] KEY_LAYOUT [4][4] = '{
        '{KEY_1,    KEY_2, KEY_3,    KEY_A},
        '{KEY_4,    KEY_5, KEY_6,    KEY_B},
        '{KEY_7,    KEY_8, KEY_9,    KEY_C},
        '{KEY_STAR, KEY_0, KEY_HASH, KEY_D}
    };

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/keypad_code_to_pos.sv
// Combinational lookup of a key code to its (row, col) position on the keypad.
module keypad_code_to_pos
    import keypad_pkg::*;
(
    input  logic [3:0] code,
    output logic [1:0] row,
    output logic [1:0] col
);

    always_comb begin
        row = 2'd0;
        col = 2'd0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (KEY_LAYOUT[r][c] == code) begin
                    row = 2'(r);
                    col = 2'(c);
                end
            end
        end
    end

endmodule

// File: rtl/keypad_emulator.sv
// Emulates a matrix keypad press (with optional contact bounce) against an
// external column scanner, one key per request.
//
// state         | meaning
// ST_IDLE       | waiting for key_valid
// ST_BOUNCE_IN  | press bounce, pressed toggles every BOUNCE_PERIOD
// ST_HOLD       | key held down for HOLD_CYCLES
// ST_BOUNCE_OUT | release bounce, starts released
// ST_GAP        | key released for GAP_CYCLES, then done
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int HOLD_CYCLES    = 1000000,
    parameter int GAP_CYCLES     = 1000000,
    parameter int BOUNCE_TOGGLES = 4,
    parameter int BOUNCE_PERIOD  = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_code,
    input  logic       key_valid,
    output logic       key_ready,
    input  logic [3:0] COLUMN,
    output logic [3:0] LINE,
    output logic       busy,
    output logic       done
);

    localparam int MAX_LEN = max_of(max_of(HOLD_CYCLES, GAP_CYCLES),
                                    max_of(BOUNCE_PERIOD, 2 * BOUNCE_TOGGLES));
    localparam int CW = $clog2(MAX_LEN + 1);

    localparam logic [CW-1:0] HOLD_LOAD   = CW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
    localparam logic [CW-1:0] GAP_LOAD    = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [CW-1:0] PERIOD_LOAD = CW'((BOUNCE_PERIOD > 0) ? BOUNCE_PERIOD - 1 : 0);
    localparam logic [CW-1:0] TOG_LOAD    = CW'((BOUNCE_TOGGLES > 0) ? 2 * BOUNCE_TOGGLES - 1 : 0);

    logic [2:0]    state;
    logic          pressed;
    logic [CW-1:0] cnt;
    logic [CW-1:0] tog;
    logic [1:0]    row;
    logic [1:0]    col;
    logic [1:0]    dec_row;
    logic [1:0]    dec_col;
    logic [3:0]    line_next;

    keypad_code_to_pos u_code_to_pos (
        .code (key_code),
        .row  (dec_row),
        .col  (dec_col)
    );

    assign key_ready = (state == ST_IDLE) && !rst;
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            pressed <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            tog     <= '0;
            row     <= 2'd0;
            col     <= 2'd0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (key_valid && key_ready) begin
                        row     <= dec_row;
                        col     <= dec_col;
                        pressed <= 1'b1;
                        if (BOUNCE_TOGGLES > 0) begin
                            state <= ST_BOUNCE_IN;
                            cnt   <= PERIOD_LOAD;
                            tog   <= TOG_LOAD;
                        end else begin
                            state <= ST_HOLD;
                            cnt   <= HOLD_LOAD;
                        end
                    end
                end
                ST_BOUNCE_IN, ST_BOUNCE_OUT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (tog != '0) begin
                        tog     <= tog - CW'(1);
                        pressed <= ~pressed;
                        cnt     <= PERIOD_LOAD;
                    end else if (state == ST_BOUNCE_IN) begin
                        state   <= ST_HOLD;
                        pressed <= 1'b1;
                        cnt     <= HOLD_LOAD;
                    end else begin
                        state   <= ST_GAP;
                        pressed <= 1'b0;
                        cnt     <= GAP_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (BOUNCE_TOGGLES > 0) begin
                        state   <= ST_BOUNCE_OUT;
                        pressed <= 1'b0;
                        cnt     <= PERIOD_LOAD;
                        tog     <= TOG_LOAD;
                    end else begin
                        state   <= ST_GAP;
                        pressed <= 1'b0;
                        cnt     <= GAP_LOAD;
                    end
                end
                ST_GAP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else begin
                        state <= ST_IDLE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    pressed <= 1'b0;
                end
            endcase
        end
    end

    // Only the selected row can be pulled low, and only by the selected column.
    always_comb begin
        line_next      = 4'b1111;
        line_next[row] = ~(pressed & ~COLUMN[col]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            LINE <= 4'b1111;
        end else begin
            LINE <= line_next;
        end
    end

endmodule
